sipo_rx_ctrl: RTL

SIPO_RX_CTRL -- requirements
Module: sipo_rx_ctrl

---
 rtl/sipo_rx_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sipo_rx_ctrl.sv
// Serial-in parallel-out receiver: start/data/stop framing, LSB first,
// with a one-word valid/ready output buffer and error/overrun pulses.
module sipo_rx_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             bit_en,
    input  logic             ser_in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             shift_en,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             shift_en_q, shift_en_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             deliver;

    // Next-state, datapath and output-buffer handshake logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = valid_q;
        shift_en_d  = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!ser_in) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shreg_d    = {ser_in, shreg_q[WIDTH-1:1]};
                    shift_en_d = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    state_d = IDLE;
                    if (ser_in) begin
                        deliver = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // A consumer accepting in the same cycle frees the slot.
        if (deliver) begin
            if (!valid_q || out_ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            shift_en_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            shift_en_q  <= shift_en_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign shift_en  = shift_en_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
